seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-sequence detector. Serial input is qualified by a valid strobe.
- Pattern is up to MAX_LEN bits. Pattern, length and overlap mode are loaded through a configuration strobe.
- Produces a registered one-cycle match pulse and a saturating match counter.
- Sits behind serial deserialiser and front-end logic. Replaces fixed-pattern, fixed-mode detectors.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of pat_len; must hold MAX_LEN.
- CNT_W, 8: width of match_cnt.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- x, input, 1: serial data bit.
- x_valid, input, 1: x sampled only when 1.
- cfg_load, input, 1: latch pattern, pat_len and overlap_en; clears history.
- pattern, input, MAX_LEN: target sequence. Bit pat_len-1 is the first bit received; bit 0 is the last.
- pat_len, input, LEN_W: pattern length.
- overlap_en, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- cnt_clr, input, 1: synchronous clear of match_cnt.
- z, output, 1: registered match pulse.
- match_cnt, output, CNT_W: saturating count of matches.
- cfg_len_err, output, 1: sticky flag; last load had pat_len==0 or pat_len>MAX_LEN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - z=0, match_cnt=0, cfg_len_err=0.
  - Shift history=0, fill=0.
  - Active config: pattern=0, len=0, overlap=0. This disables detection until the first cfg_load.
- Configuration, on a clock edge with cfg_load=1:
  - Latch pattern and overlap_en.
  - len = pat_len, clamped to MAX_LEN if larger.
  - cfg_len_err = 1 if pat_len==0 or pat_len>MAX_LEN, else 0.
  - Clear history and fill.
  - Any x_valid in the same cycle is discarded; cfg_load has priority.
  - z is forced 0 in the following cycle.
  - match_cnt is unaffected.
- Datapath:
  - hist is a MAX_LEN-bit shift register. On an accepted bit: hist <= {hist[MAX_LEN-2:0], x}.
  - fill counts accepted bits since the last clear. It saturates at MAX_LEN.
  - cand = {hist[MAX_LEN-2:0], x}.
- Match condition, evaluated on an accepted bit:
  - len != 0, and
  - fill+1 >= len, and
  - the low len bits of cand equal the low len bits of the latched pattern.
  - Bits of pattern at or above len are ignored.
- Output timing:
  - z=1 for exactly one cycle, in the cycle after the clock edge that accepted the completing bit (latency 1).
  - Otherwise z=0. z is never combinational from x.
  - Cycles with x_valid=0 leave hist and fill unchanged and drive z=0.
- Mode on a match:
  - overlap=1: hist and fill update normally, so the match tail may start the next match.
  - overlap=0: fill <= 0 and hist <= 0 after the match. The next match needs len fresh bits.
- Counter:
  - Each match increments match_cnt, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets match_cnt=0 and has priority over a same-cycle match.
  - The z pulse for that same-cycle match is still produced.
- Mode summary: a non-overlapping, 3-bit, "101" configuration is the special case len=3, pattern=3'b101, overlap=0.
- Reset mid-stream: immediate return to the reset state, including loss of config. Software must reload.

Test Plan:
1. Reset, then cfg_load pattern=8'b101, pat_len=3, overlap_en=0. Stream 1,0,1,0,1 with x_valid=1 -> z high once, in the cycle after the 3rd bit; match_cnt=1.
2. Same config with overlap_en=1. Stream 1,0,1,0,1 -> z pulses after bit 3 and after bit 5; match_cnt=2.
3. pat_len=8, pattern=8'hA5. Stream 0xA5 MSB-first with x_valid toggling 1/0 every cycle -> single z pulse 1 cycle after the 8th valid bit; no pulse earlier; gaps do not corrupt history.
4. cfg_load with pat_len=0 -> cfg_len_err=1; stream all 1s -> z never asserts. Then cfg_load pat_len=9 (MAX_LEN=8) -> cfg_len_err=1 and len clamped to 8; pattern 8'hFF matches after 8 ones.
5. CNT_W=2, pattern "11", overlap=1, stream eight 1s -> match_cnt saturates at 3. Assert cnt_clr in the same cycle as a match -> match_cnt=0 and z still pulses.
6. Mid-pattern: after bits 1,0 assert cfg_load (with x_valid=1, x=1), then send 1,0,1 -> no match from pre-load bits; one match after the new 3rd bit. Pulse rst_n low mid-stream -> z=0 and match_cnt=0 immediately; no detection until reload.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Bus bundle for the programmable sequence detector: serial input, config
// load and counter clear towards the detector, match results back.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_len_err;

    modport master (
        output x, x_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
        input  z, match_cnt, cfg_len_err
    );

    modport slave (
        input  x, x_valid, cfg_load, pattern, pat_len, overlap_en, cnt_clr,
        output z, match_cnt, cfg_len_err
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector with registered match
// pulse, saturating match counter and sticky config-length error flag.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic               ovl_q;
    logic               z_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               enough;
    logic               hit;

    // cfg_load wins over a same-cycle data bit
    assign accept = bus.x_valid & ~bus.cfg_load;
    assign cand   = {hist_q[MAX_LEN-2:0], bus.x};
    assign enough = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};

    // Mask selecting the low len bits of candidate and pattern
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    assign hit = accept && (len_q != '0) && enough &&
                 (((cand ^ pat_q) & len_mask) == '0);

    // Active configuration and sticky length-error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            err_q <= 1'b0;
        end else if (bus.cfg_load) begin
            pat_q <= bus.pattern;
            ovl_q <= bus.overlap_en;
            len_q <= (bus.pat_len > MAX_LEN_L) ? MAX_LEN_L : bus.pat_len;
            err_q <= (bus.pat_len == '0) || (bus.pat_len > MAX_LEN_L);
        end
    end

    // Shift history and fill level; non-overlapping matches restart from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (accept) begin
            if (hit && !ovl_q) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= cand;
                fill_q <= (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
            end
        end
    end

    // Registered one-cycle match pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else begin
            z_q <= hit;
        end
    end

    // Saturating match counter; clear beats a same-cycle match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.z           = z_q;
    assign bus.match_cnt   = cnt_q;
    assign bus.cfg_len_err = err_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   z_seen;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted bits since last clear, plus active config
    bit               mq[$];
    logic [7:0]       m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_err;
    bit               m_z;
    int               m_cnt;

    task automatic model_reset();
        mq.delete();
        m_pat = '0;
        m_len = 0;
        m_ovl = 0;
        m_err = 0;
        m_z   = 0;
        m_cnt = 0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, predict, clock, compare
    task automatic cyc(input bit xi, input bit vi, input bit ld,
                       input logic [7:0] pat, input logic [3:0] len,
                       input bit ovl, input bit clr, input string tag);
        bit hit;
        int n;
        bus.x          = xi;
        bus.x_valid    = vi;
        bus.cfg_load   = ld;
        bus.pattern    = ld ? pat : 8'($urandom);
        bus.pat_len    = ld ? len : 4'($urandom);
        bus.overlap_en = ld ? ovl : 1'($urandom);
        bus.cnt_clr    = clr;
        hit = 0;
        if (ld) begin
            m_pat = pat;
            m_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
            m_err = (len == 0) || (int'(len) > MAX_LEN);
            m_ovl = ovl;
            mq.delete();
        end else if (vi) begin
            mq.push_back(xi);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            n = mq.size();
            if (m_len != 0 && n >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (mq[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
            end
            if (hit && !m_ovl) mq.delete();
        end
        m_z = hit;
        if (clr) m_cnt = 0;
        else if (hit && m_cnt != (1 << CNT_W) - 1) m_cnt++;
        @(posedge clk);
        #1;
        if (bus.z === 1'b1) z_seen++;
        chk({tag, "_z"}, int'(bus.z), int'(m_z));
        chk({tag, "_cnt"}, int'(bus.match_cnt), m_cnt);
        chk({tag, "_err"}, int'(bus.cfg_len_err), int'(m_err));
    endtask

    task automatic bit_in(input bit xi, input bit vi, input string tag);
        cyc(xi, vi, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len,
                        input bit ovl, input string tag);
        cyc(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, tag);
    endtask

    task automatic clear_cnt(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, tag);
    endtask

    logic [7:0] a5;
    bit         s5[5];
    int         rl;

    initial begin
        errors = 0;
        checks = 0;
        z_seen = 0;
        bus.x = 0; bus.x_valid = 0; bus.cfg_load = 0; bus.pattern = '0;
        bus.pat_len = '0; bus.overlap_en = 0; bus.cnt_clr = 0;
        model_reset();
        rst_n = 0;
        #12;
        chk("rst_z", int'(bus.z), 0);
        chk("rst_cnt", int'(bus.match_cnt), 0);
        chk("rst_err", int'(bus.cfg_len_err), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // No detection before the first configuration
        for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b1, "precfg");

        // Non-overlapping 101 on 1,0,1,0,1
        s5 = '{1, 0, 1, 0, 1};
        load(8'b101, 4'd3, 1'b0, "t1_load");
        z_seen = 0;
        foreach (s5[i]) bit_in(s5[i], 1'b1, "t1");
        bit_in(1'b0, 1'b0, "t1_idle");
        chk("t1_pulses", z_seen, 1);

        // Overlapping 101
        clear_cnt("t2_clr");
        load(8'b101, 4'd3, 1'b1, "t2_load");
        z_seen = 0;
        foreach (s5[i]) bit_in(s5[i], 1'b1, "t2");
        bit_in(1'b0, 1'b0, "t2_idle");
        chk("t2_pulses", z_seen, 2);

        // 8-bit pattern with x_valid gaps between bits
        clear_cnt("t3_clr");
        load(8'hA5, 4'd8, 1'b0, "t3_load");
        a5 = 8'hA5;
        z_seen = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_in(a5[i], 1'b1, "t3");
            bit_in(1'b1, 1'b0, "t3_gap");
        end
        chk("t3_pulses", z_seen, 1);

        // Zero length disables detection; oversize length clamps to MAX_LEN
        load(8'hFF, 4'd0, 1'b1, "t4_len0");
        z_seen = 0;
        for (int i = 0; i < 10; i++) bit_in(1'b1, 1'b1, "t4_ones");
        chk("t4_nopulse", z_seen, 0);
        load(8'hFF, 4'd9, 1'b0, "t4_len9");
        z_seen = 0;
        for (int i = 0; i < 8; i++) bit_in(1'b1, 1'b1, "t4_ff");
        chk("t4_pulses", z_seen, 1);

        // Counter saturation and clear colliding with a match
        clear_cnt("t5_clr0");
        load(8'b11, 4'd2, 1'b1, "t5_load");
        for (int i = 0; i < 8; i++) bit_in(1'b1, 1'b1, "t5_ones");
        chk("t5_sat", int'(bus.match_cnt), 3);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, "t5_clrhit");
        chk("t5_clr_cnt", int'(bus.match_cnt), 0);
        chk("t5_clr_z", int'(bus.z), 1);

        // Reload mid-pattern discards the older bits and the same-cycle bit
        load(8'b101, 4'd3, 1'b0, "t6_load");
        bit_in(1'b1, 1'b1, "t6_pre");
        bit_in(1'b0, 1'b1, "t6_pre");
        cyc(1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b0, 1'b0, "t6_reload");
        bit_in(1'b1, 1'b1, "t6_post");
        bit_in(1'b0, 1'b1, "t6_post");
        bit_in(1'b1, 1'b1, "t6_post");

        // Asynchronous reset mid-stream
        bit_in(1'b0, 1'b1, "t6_s");
        bit_in(1'b1, 1'b1, "t6_s");
        bus.x = 1'b1; bus.x_valid = 1'b1;
        rst_n = 0;
        model_reset();
        #2;
        chk("t6_rst_z", int'(bus.z), 0);
        chk("t6_rst_cnt", int'(bus.match_cnt), 0);
        chk("t6_rst_err", int'(bus.cfg_len_err), 0);
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
        z_seen = 0;
        foreach (s5[i]) bit_in(s5[i], 1'b1, "t6_noreload");
        chk("t6_nopulse", z_seen, 0);

        // Random traffic with occasional reconfiguration and clears
        load(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom), "rnd_load0");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                rl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15)
                                                 : $urandom_range(1, 4);
                cyc(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 4'(rl),
                    1'($urandom), 1'($urandom_range(0, 7) == 0), "rnd_cfg");
            end else begin
                cyc(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00,
                    4'h0, 1'b0, ($urandom_range(0, 15) == 0), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
